// File: rtl/canvas_pkg.sv
// Shared constants, types and helpers for the keyboard paint canvas.
package canvas_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_COLOR = 8'h21;
  localparam logic [7:0] SC_PAINT = 8'h29;
  localparam logic [7:0] SC_HOME  = 8'h2D;
  localparam logic [7:0] SC_CLEAR = 8'h76;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_e;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic color;
    logic paint;
    logic home;
    logic clear;
  } cmd_t;

  // Palette index to per-channel on/off flags {R,G,B}.
  function automatic logic [2:0] palette_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    palette_rgb = 3'b000;
      3'd1:    palette_rgb = 3'b100;
      3'd2:    palette_rgb = 3'b010;
      3'd3:    palette_rgb = 3'b001;
      3'd4:    palette_rgb = 3'b110;
      3'd5:    palette_rgb = 3'b011;
      3'd6:    palette_rgb = 3'b101;
      default: palette_rgb = 3'b111;
    endcase
  endfunction

  // Number of whole tiles along one axis.
  function automatic int unsigned grid_dim(input int unsigned active, input int unsigned cell_log2);
    return active >> cell_log2;
  endfunction

  // Index width for n entries, never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ps2_cmd_decoder.sv
// PS/2 set-2 byte framing and command pulse generation.
module ps2_cmd_decoder
  import canvas_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scancode,
  input  logic       key_pressed,
  input  logic       busy,
  output logic       cmd_up,
  output logic       cmd_down,
  output logic       cmd_left,
  output logic       cmd_right,
  output logic       cmd_color,
  output logic       cmd_paint,
  output logic       cmd_home,
  output logic       cmd_clear
);

  logic       key_s1_q, key_s1_d;
  logic       key_s2_q, key_s2_d;
  logic       key_s3_q, key_s3_d;
  logic       byte_vld_q, byte_vld_d;
  logic [7:0] code_q, code_d;
  dec_state_e state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic       exec_c;
  logic       ext_c;

  // Synchroniser, byte strobe, framing FSM and command decode.
  always_comb begin
    key_s1_d   = key_pressed;
    key_s2_d   = key_s1_q;
    key_s3_d   = key_s2_q;
    byte_vld_d = key_s2_q & ~key_s3_q;
    code_d     = byte_vld_d ? scancode : code_q;
    state_d    = state_q;
    cmd_d      = '0;
    exec_c     = 1'b0;
    ext_c      = 1'b0;

    if (byte_vld_q) begin
      case (state_q)
        DEC_IDLE: begin
          if (code_q == SC_EXT)      state_d = DEC_EXT;
          else if (code_q == SC_BRK) state_d = DEC_BRK;
          else                       exec_c  = 1'b1;
        end
        DEC_EXT: begin
          if (code_q == SC_BRK) begin
            state_d = DEC_EXT_BRK;
          end else begin
            exec_c  = 1'b1;
            ext_c   = 1'b1;
            state_d = DEC_IDLE;
          end
        end
        default: state_d = DEC_IDLE;
      endcase
    end

    // Framing still advances while busy; only the action is dropped.
    if (exec_c && !busy) begin
      if (ext_c) begin
        case (code_q)
          SC_UP:    cmd_d.up    = 1'b1;
          SC_DOWN:  cmd_d.down  = 1'b1;
          SC_LEFT:  cmd_d.left  = 1'b1;
          SC_RIGHT: cmd_d.right = 1'b1;
          default:  ;
        endcase
      end else begin
        case (code_q)
          SC_COLOR: cmd_d.color = 1'b1;
          SC_PAINT: cmd_d.paint = 1'b1;
          SC_HOME:  cmd_d.home  = 1'b1;
          SC_CLEAR: cmd_d.clear = 1'b1;
          default:  ;
        endcase
      end
    end
  end

  // Decoder state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1_q   <= 1'b0;
      key_s2_q   <= 1'b0;
      key_s3_q   <= 1'b0;
      byte_vld_q <= 1'b0;
      code_q     <= '0;
      state_q    <= DEC_IDLE;
      cmd_q      <= '0;
    end else begin
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      key_s3_q   <= key_s3_d;
      byte_vld_q <= byte_vld_d;
      code_q     <= code_d;
      state_q    <= state_d;
      cmd_q      <= cmd_d;
    end
  end

  assign cmd_up    = cmd_q.up;
  assign cmd_down  = cmd_q.down;
  assign cmd_left  = cmd_q.left;
  assign cmd_right = cmd_q.right;
  assign cmd_color = cmd_q.color;
  assign cmd_paint = cmd_q.paint;
  assign cmd_home  = cmd_q.home;
  assign cmd_clear = cmd_q.clear;

endmodule

// File: rtl/kbd_canvas_painter.sv
// Keyboard-driven tile canvas: cursor, brush, cell RAM and pixel pipeline.
module kbd_canvas_painter
  import canvas_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned CELL_LOG2 = 4,
  parameter int unsigned CB        = 4,
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned WRAP_EN   = 0
) (
  input  logic                                                clk,
  input  logic                                                btnC,
  input  logic [7:0]                                          scancode,
  input  logic                                                keyPressed,
  input  logic [COORD_W-1:0]                                  XCoord,
  input  logic [COORD_W-1:0]                                  YCoord,
  output logic [3*CB-1:0]                                     pixel_color,
  output logic [clog2_min1(grid_dim(H_ACTIVE, CELL_LOG2))-1:0] cursor_x,
  output logic [clog2_min1(grid_dim(V_ACTIVE, CELL_LOG2))-1:0] cursor_y,
  output logic [2:0]                                          color_idx,
  output logic                                                busy
);

  localparam int unsigned GW     = grid_dim(H_ACTIVE, CELL_LOG2);
  localparam int unsigned GH     = grid_dim(V_ACTIVE, CELL_LOG2);
  localparam int unsigned XW     = clog2_min1(GW);
  localparam int unsigned YW     = clog2_min1(GH);
  localparam int unsigned DEPTH  = GW * GH;
  localparam int unsigned ADDR_W = clog2_min1(DEPTH);

  logic cmd_up, cmd_down, cmd_left, cmd_right;
  logic cmd_color, cmd_paint, cmd_home, cmd_clear;

  logic [XW-1:0]     cur_x_q, cur_x_d;
  logic [YW-1:0]     cur_y_q, cur_y_d;
  logic [2:0]        color_q, color_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              active_q, active_d;
  logic              hit_q, hit_d;
  logic [3*CB-1:0]   pixel_q, pixel_d;
  logic [2:0]        rd_data_q;

  logic              we_c;
  logic [ADDR_W-1:0] wa_c;
  logic [2:0]        wd_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [COORD_W-1:0] cell_x_c, cell_y_c;
  logic [2:0]        rgb_c;

  logic [2:0] mem [DEPTH];

  ps2_cmd_decoder u_dec (
    .clk         (clk),
    .rst         (btnC),
    .scancode    (scancode),
    .key_pressed (keyPressed),
    .busy        (busy_q),
    .cmd_up      (cmd_up),
    .cmd_down    (cmd_down),
    .cmd_left    (cmd_left),
    .cmd_right   (cmd_right),
    .cmd_color   (cmd_color),
    .cmd_paint   (cmd_paint),
    .cmd_home    (cmd_home),
    .cmd_clear   (cmd_clear)
  );

  // Cursor, brush, clear sweep and RAM write port selection.
  always_comb begin
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    color_d    = color_q + {2'b00, cmd_color};
    busy_d     = busy_q;
    clr_addr_d = clr_addr_q;
    we_c       = 1'b0;
    wa_c       = '0;
    wd_c       = '0;

    if (cmd_home) begin
      cur_x_d = XW'(GW / 2);
      cur_y_d = YW'(GH / 2);
    end
    if (cmd_left) begin
      if (cur_x_q == '0) cur_x_d = (WRAP_EN != 0) ? XW'(GW - 1) : '0;
      else               cur_x_d = cur_x_q - XW'(1);
    end
    if (cmd_right) begin
      if (cur_x_q == XW'(GW - 1)) cur_x_d = (WRAP_EN != 0) ? '0 : cur_x_q;
      else                        cur_x_d = cur_x_q + XW'(1);
    end
    if (cmd_up) begin
      if (cur_y_q == '0) cur_y_d = (WRAP_EN != 0) ? YW'(GH - 1) : '0;
      else               cur_y_d = cur_y_q - YW'(1);
    end
    if (cmd_down) begin
      if (cur_y_q == YW'(GH - 1)) cur_y_d = (WRAP_EN != 0) ? '0 : cur_y_q;
      else                        cur_y_d = cur_y_q + YW'(1);
    end

    if (busy_q) begin
      we_c       = 1'b1;
      wa_c       = clr_addr_q;
      clr_addr_d = clr_addr_q + ADDR_W'(1);
      if (clr_addr_q == ADDR_W'(DEPTH - 1)) busy_d = 1'b0;
    end else if (cmd_clear) begin
      busy_d     = 1'b1;
      clr_addr_d = '0;
    end else if (cmd_paint) begin
      we_c = 1'b1;
      wa_c = ADDR_W'(cur_y_q) * ADDR_W'(GW) + ADDR_W'(cur_x_q);
      wd_c = color_q;
    end
  end

  // Pixel stage 0: cell lookup address, active and cursor-hit flags.
  always_comb begin
    cell_x_c  = XCoord >> CELL_LOG2;
    cell_y_c  = YCoord >> CELL_LOG2;
    active_d  = (32'(XCoord) < H_ACTIVE) && (32'(YCoord) < V_ACTIVE);
    hit_d     = active_d && (cell_x_c == COORD_W'(cur_x_q)) && (cell_y_c == COORD_W'(cur_y_q));
    rd_addr_c = '0;
    if (active_d) rd_addr_c = ADDR_W'(cell_y_c) * ADDR_W'(GW) + ADDR_W'(cell_x_c);
  end

  // Pixel stage 1: palette lookup, cursor inversion, blanking.
  always_comb begin
    rgb_c   = palette_rgb(rd_data_q) ^ {3{hit_q}};
    pixel_d = '0;
    if (active_q) pixel_d = {{CB{rgb_c[2]}}, {CB{rgb_c[1]}}, {CB{rgb_c[0]}}};
  end

  // Control and pipeline registers; reset also launches a clear sweep.
  always_ff @(posedge clk) begin
    if (btnC) begin
      cur_x_q    <= XW'(GW / 2);
      cur_y_q    <= YW'(GH / 2);
      color_q    <= 3'd1;
      busy_q     <= 1'b1;
      clr_addr_q <= '0;
      active_q   <= 1'b0;
      hit_q      <= 1'b0;
      pixel_q    <= '0;
    end else begin
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      color_q    <= color_d;
      busy_q     <= busy_d;
      clr_addr_q <= clr_addr_d;
      active_q   <= active_d;
      hit_q      <= hit_d;
      pixel_q    <= pixel_d;
    end
  end

  // Cell RAM: one write port, one registered read port returning old data on collision.
  always_ff @(posedge clk) begin
    if (we_c) mem[wa_c] <= wd_c;
    rd_data_q <= mem[rd_addr_c];
  end

  assign pixel_color = pixel_q;
  assign cursor_x    = cur_x_q;
  assign cursor_y    = cur_y_q;
  assign color_idx   = color_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_kbd_canvas_painter.sv
// Self-checking bench for kbd_canvas_painter (saturating and wrapping instances).
module tb_kbd_canvas_painter;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] exp;
  } pix_vec_t;

  typedef struct {
    logic [11:0] exp;
    int          due;
    int          idx;
  } sb_t;

  logic        clk = 1'b0;
  logic        btnC;
  logic [7:0]  scancode;
  logic        keyPressed;
  logic [9:0]  XCoord, YCoord;
  logic [11:0] pixel_color, pixel_color_w;
  logic [5:0]  cursor_x, cursor_x_w;
  logic [4:0]  cursor_y, cursor_y_w;
  logic [2:0]  color_idx, color_idx_w;
  logic        busy, busy_w;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  pix_vec_t vecs[$];
  sb_t      sb[$];
  string    tag;

  kbd_canvas_painter #(.WRAP_EN(0)) dut (
    .clk (clk), .btnC (btnC), .scancode (scancode), .keyPressed (keyPressed),
    .XCoord (XCoord), .YCoord (YCoord), .pixel_color (pixel_color),
    .cursor_x (cursor_x), .cursor_y (cursor_y), .color_idx (color_idx), .busy (busy)
  );

  kbd_canvas_painter #(.WRAP_EN(1)) dut_w (
    .clk (clk), .btnC (btnC), .scancode (scancode), .keyPressed (keyPressed),
    .XCoord (XCoord), .YCoord (YCoord), .pixel_color (pixel_color_w),
    .cursor_x (cursor_x_w), .cursor_y (cursor_y_w), .color_idx (color_idx_w), .busy (busy_w)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [9:0] x, input logic [9:0] y, input logic [11:0] exp);
    pix_vec_t v;
    v.x = x; v.y = y; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Compare every scoreboard entry whose output cycle has arrived.
  task automatic drain();
    sb_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk($sformatf("%s_pix%0d", tag, e.idx), 32'(pixel_color), 32'(e.exp));
    end
  endtask

  // Stream the vector table through the raster inputs, one coordinate per clock.
  task automatic run_vectors(input string name);
    sb_t e;
    tag = name;
    foreach (vecs[i]) begin
      @(negedge clk);
      XCoord = vecs[i].x;
      YCoord = vecs[i].y;
      e.exp = vecs[i].exp; e.due = cyc + 2; e.idx = i;
      sb.push_back(e);
      drain();
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drain();
    end
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    sb.delete();
    vecs.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    scancode   = b;
    keyPressed = 1'b1;
    repeat (3) @(negedge clk);
    keyPressed = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_ext(input logic [7:0] b);
    send_byte(8'hE0);
    send_byte(b);
  endtask

  // Count consecutive busy samples starting at the current negedge.
  task automatic count_busy_now(output int n);
    n = 0;
    for (int it = 0; it < 3000; it++) begin
      if (busy) n++;
      else break;
      @(negedge clk);
    end
  endtask

  // Press a key that should start a sweep and measure its length; optionally inject a key mid-sweep.
  task automatic sweep_run(input logic [7:0] code, input bit inject, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    @(negedge clk);
    scancode   = code;
    keyPressed = 1'b1;
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      if (it == 3) keyPressed = 1'b0;
      if (busy) begin
        seen = 1'b1;
        n++;
      end else if (seen) begin
        break;
      end
      if (inject && n == 100) begin
        scancode   = 8'h21;
        keyPressed = 1'b1;
      end
      if (inject && n == 104) keyPressed = 1'b0;
    end
    keyPressed = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    btnC       = 1'b1;
    keyPressed = 1'b0;
    scancode   = 8'h00;
    XCoord     = '0;
    YCoord     = '0;
    repeat (3) @(negedge clk);

    chk("rst_pixel", 32'(pixel_color), 32'h000);
    chk("rst_cx",    32'(cursor_x),    32'd20);
    chk("rst_cy",    32'(cursor_y),    32'd15);
    chk("rst_color", 32'(color_idx),   32'd1);
    chk("rst_busy",  32'(busy),        32'd1);

    btnC = 1'b0;
    count_busy_now(n);
    chk("boot_sweep_len", 32'(n), 32'd1200);
    chk("boot_busy_w", 32'(busy_w), 32'd0);
    chk("boot_cx", 32'(cursor_x), 32'd20);
    chk("boot_cy", 32'(cursor_y), 32'd15);
    chk("boot_color", 32'(color_idx), 32'd1);

    add_vec(10'd0,    10'd0,    12'h000);
    add_vec(10'd639,  10'd479,  12'h000);
    add_vec(10'd320,  10'd240,  12'hFFF);
    add_vec(10'd335,  10'd255,  12'hFFF);
    add_vec(10'd336,  10'd240,  12'h000);
    add_vec(10'd319,  10'd240,  12'h000);
    add_vec(10'd320,  10'd239,  12'h000);
    add_vec(10'd700,  10'd10,   12'h000);
    add_vec(10'd10,   10'd500,  12'h000);
    add_vec(10'd1023, 10'd1023, 12'h000);
    run_vectors("boot");

    send_ext(8'h74);
    chk("right_cx", 32'(cursor_x), 32'd21);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    chk("right_brk_cx", 32'(cursor_x), 32'd21);
    chk("right_brk_cy", 32'(cursor_y), 32'd15);
    chk("right_cx_w", 32'(cursor_x_w), 32'd21);

    send_byte(8'h21);
    send_byte(8'h21);
    send_byte(8'h29);
    chk("brush_color", 32'(color_idx), 32'd3);

    add_vec(10'd336, 10'd240, 12'hFF0);
    add_vec(10'd351, 10'd255, 12'hFF0);
    add_vec(10'd320, 10'd240, 12'h000);
    run_vectors("paint");

    send_ext(8'h6B);
    chk("left_cx", 32'(cursor_x), 32'd20);
    send_byte(8'hF0); send_byte(8'h29);
    send_byte(8'hF0); send_byte(8'h21);
    chk("brk_color", 32'(color_idx), 32'd3);

    add_vec(10'd336, 10'd240, 12'h00F);
    add_vec(10'd320, 10'd240, 12'hFFF);
    add_vec(10'd700, 10'd240, 12'h000);
    add_vec(10'd336, 10'd500, 12'h000);
    run_vectors("moved");

    for (int i = 0; i < 21; i++) send_ext(8'h6B);
    chk("sat_left_cx",  32'(cursor_x),   32'd0);
    chk("wrap_left_cx", 32'(cursor_x_w), 32'd39);
    for (int i = 0; i < 4; i++) send_ext(8'h6B);
    chk("sat_left25_cx",  32'(cursor_x),   32'd0);
    chk("wrap_left25_cx", 32'(cursor_x_w), 32'd35);

    send_byte(8'h2D);
    chk("home_cx",   32'(cursor_x),   32'd20);
    chk("home_cy",   32'(cursor_y),   32'd15);
    chk("home_cx_w", 32'(cursor_x_w), 32'd20);
    send_ext(8'h75);
    chk("up_cy", 32'(cursor_y), 32'd14);
    send_ext(8'h72);
    send_ext(8'h72);
    chk("down_cy", 32'(cursor_y), 32'd16);
    send_byte(8'h2D);
    chk("home2_cy", 32'(cursor_y), 32'd15);

    add_vec(10'd336, 10'd240, 12'h00F);
    run_vectors("home");

    sweep_run(8'h76, 1'b1, n);
    chk("esc_sweep_len", 32'(n), 32'd1200);
    chk("esc_color_kept", 32'(color_idx), 32'd3);

    add_vec(10'd336, 10'd240, 12'h000);
    add_vec(10'd320, 10'd240, 12'hFFF);
    run_vectors("cleared");

    send_ext(8'h74);
    chk("pre_rst_cx", 32'(cursor_x), 32'd21);
    @(negedge clk);
    scancode   = 8'h76;
    keyPressed = 1'b1;
    n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_sweep_start", 32'(busy), 32'd1);
    keyPressed = 1'b0;
    repeat (300) @(negedge clk);
    btnC = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_cx",    32'(cursor_x),  32'd20);
    chk("mid_rst_cy",    32'(cursor_y),  32'd15);
    chk("mid_rst_color", 32'(color_idx), 32'd1);
    chk("mid_rst_busy",  32'(busy),      32'd1);
    btnC = 1'b0;
    count_busy_now(n);
    chk("restart_sweep_len", 32'(n), 32'd1200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
